// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake into the buffered UART transmitter.
// The producer drives data/valid and the transmitter answers with ready.
interface uart_tx_fifo_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO through a valid/ready handshake
// and leave LSB first at DELAY_FRAMES clocks per bit, with no idle gap between frames.
module uart_tx_fifo #(
   parameter int DELAY_FRAMES = 234,
   parameter int FIFO_AW      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_fifo_if.slave    in_if,
   output logic             uart_tx_o,
   output logic             busy_o,
   output logic [FIFO_AW:0] fifo_count_o
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = $clog2(DELAY_FRAMES);
   localparam logic [CW-1:0]    CNT_LAST   = CW'(DELAY_FRAMES - 1);
   localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               full, empty, push, pop, cnt_last;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2:0]         bit_q;
   logic [7:0]         shift_q;
   logic               tx_q;

   assign full     = (count_q == COUNT_FULL);
   assign empty    = (count_q == '0);
   assign cnt_last = (cnt_q == CNT_LAST);

   // Ready depends on the count alone, so a full FIFO never refills in the cycle it pops.
   assign in_if.in_ready = !full;
   assign push           = in_if.in_valid && !full;
   assign pop            = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && cnt_last));

   assign uart_tx_o    = tx_q;
   assign busy_o       = (state_q != S_IDLE) || !empty;
   assign fifo_count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage has no reset so it can map onto RAM; the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_if.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               tx_q  <= 1'b1;
               cnt_q <= '0;
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  tx_q    <= 1'b0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (cnt_last) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  shift_q <= {1'b0, shift_q[7:1]};
                  state_q <= S_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_last) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[0];
                     shift_q <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_last) begin
                  cnt_q <= '0;
                  if (pop) begin
                     shift_q <= mem_q[rd_ptr_q];
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               cnt_q   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table of single-byte frames plus hand-written
// back-to-back, full, simultaneous push/pop and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
   localparam int DF    = 4;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int FRAME = 10 * DF;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          uart_tx;
   logic          busy;
   logic [AW:0]   fifo_count;

   uart_tx_fifo_if bus ();

   uart_tx_fifo #(
      .DELAY_FRAMES(DF),
      .FIFO_AW     (AW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_if       (bus),
      .uart_tx_o   (uart_tx),
      .busy_o      (busy),
      .fifo_count_o(fifo_count)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   int         rx_count = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Line monitor: captures every sample of a frame, demands constant bit cells,
   // and compares the decoded byte against the scoreboard head.
   logic mon_active = 1'b0;
   int   mon_n = 0;
   logic fs [FRAME];

   task automatic mon_frame();
      logic       glitch;
      logic [7:0] data;
      logic [7:0] e;
      glitch = 1'b0;
      for (int i = 0; i < 10; i++)
         for (int j = 1; j < DF; j++)
            if (fs[i*DF+j] !== fs[i*DF]) glitch = 1'b1;
      for (int k = 0; k < 8; k++) data[k] = fs[(k+1)*DF];
      chk("frame_bit_width", glitch, 0);
      chk("frame_stop_bit", fs[9*DF], 1);
      if (exp_q.size() == 0) begin
         chk("frame_unexpected", data, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         chk("frame_data", data, e);
      end
      rx_count++;
      $display("frame %0d: byte 0x%02h started at cycle %0d", rx_count, data, start_q[$]);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 1'b0;
         mon_n      = 0;
      end else if (!mon_active) begin
         if (uart_tx === 1'b0) begin
            mon_active = 1'b1;
            fs[0]      = 1'b0;
            mon_n      = 1;
            start_q.push_back(cyc);
         end
      end else begin
         fs[mon_n] = uart_tx;
         mon_n++;
         if (mon_n == FRAME) begin
            mon_active = 1'b0;
            mon_frame();
         end
      end
   end

   // Called at a negedge; leaves in_valid high so callers can stream bytes.
   task automatic drive_push(input logic [7:0] d);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      chk("push_ready", bus.in_ready, 1);
      exp_q.push_back(d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_active || busy !== 1'b0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", (n < bound), 1);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_bits;   // bit i = line value in bit cell i (start, d0..d7, stop)
   } vec_t;

   vec_t vecs[7];

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       s [FRAME+2];
      logic [9:0] got;
      logic [AW:0] cnt0, cnt1, c3 [3];
      logic       busy40, busy41;
      int         lows, n, bad, rx0;

      vecs[0] = '{8'h55, 10'h2AA};
      vecs[1] = '{8'h00, 10'h200};
      vecs[2] = '{8'hFF, 10'h3FE};
      vecs[3] = '{8'hA3, 10'h346};
      vecs[4] = '{8'h01, 10'h202};
      vecs[5] = '{8'h80, 10'h300};
      vecs[6] = '{8'h3C, 10'h278};

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset and idle
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_line_held", uart_tx, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_uart_tx", uart_tx, 1);
      chk("reset_in_ready", bus.in_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_count", fifo_count, 0);
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
      end
      chk("idle_activity", lows, 0);
      chk("idle_frames", rx_count, 0);

      // Table-driven single-byte frames
      for (int v = 0; v < 7; v++) begin
         drive_push(vecs[v].data);
         bus.in_valid = 1'b0;
         s[0] = uart_tx;
         cnt0 = fifo_count;
         for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            s[k] = uart_tx;
            if (k == 1) cnt1 = fifo_count;
            if (k == FRAME) busy40 = busy;
            if (k == FRAME + 1) busy41 = busy;
         end
         for (int i = 0; i < 10; i++) got[i] = s[1 + i*DF + DF/2];
         chk("vec_line_before_start", s[0], 1);
         chk("vec_start_latency", s[1], 0);
         chk("vec_bits", got, vecs[v].exp_bits);
         chk("vec_count_after_push", cnt0, 1);
         chk("vec_count_after_pop", cnt1, 0);
         chk("vec_busy_last_cycle", busy40, 1);
         chk("vec_busy_fall", busy41, 0);
         chk("vec_line_idle_after", s[FRAME+1], 1);
      end

      // Back-to-back bytes
      start_q.delete();
      drive_push(8'h00); c3[0] = fifo_count;
      drive_push(8'hFF); c3[1] = fifo_count;
      drive_push(8'hA3); c3[2] = fifo_count;
      bus.in_valid = 1'b0;
      chk("b2b_count0", c3[0], 1);
      chk("b2b_count1", c3[1], 1);
      chk("b2b_count2", c3[2], 2);
      wait_drain(400);
      chk("b2b_frames", start_q.size(), 3);
      chk("b2b_gap1", (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, FRAME);
      chk("b2b_gap2", (start_q.size() >= 3) ? start_q[2] - start_q[0] : -1, 2 * FRAME);

      // Full FIFO with a byte held while full
      rx0 = rx_count;
      drive_push(8'h10);
      bus.in_valid = 1'b0;
      repeat (8) @(negedge clk);
      for (int b = 8'h11; b <= 8'h20; b++) drive_push(8'(b));
      chk("full_count", fifo_count, DEPTH);
      chk("full_in_ready", bus.in_ready, 0);
      bus.in_data  = 8'hAA;
      bus.in_valid = 1'b1;
      n   = 0;
      bad = 0;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         if (fifo_count !== DEPTH) bad++;
         @(negedge clk);
         n++;
      end
      chk("full_hold_count", bad, 0);
      chk("full_held_cycles", n, 17);
      chk("full_after_pop", fifo_count, DEPTH - 1);
      exp_q.push_back(8'hAA);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("full_refill", fifo_count, DEPTH);
      wait_drain(1200);
      chk("full_frames", rx_count - rx0, 18);

      // Simultaneous push and pop at end of STOP
      drive_push(8'h61);
      drive_push(8'h62);
      drive_push(8'h63);
      drive_push(8'h64);
      bus.in_valid = 1'b0;
      repeat (FRAME - 3) @(negedge clk);
      chk("simul_pre_count", fifo_count, 3);
      drive_push(8'h65);
      bus.in_valid = 1'b0;
      chk("simul_count", fifo_count, 3);
      chk("simul_restart_line", uart_tx, 0);
      wait_drain(400);

      // Reset during DATA bit 3 with five bytes queued
      rx0 = rx_count;
      drive_push(8'h00);
      for (int b = 8'h71; b <= 8'h75; b++) drive_push(8'(b));
      bus.in_valid = 1'b0;
      chk("rst_queued", fifo_count, 5);
      repeat (4 * DF - 3) @(negedge clk);
      chk("rst_pre_line", uart_tx, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_line_high", uart_tx, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      exp_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      chk("rst_no_resume", lows, 0);
      chk("rst_no_frames", rx_count - rx0, 0);
      drive_push(8'h5A);
      bus.in_valid = 1'b0;
      wait_drain(200);
      chk("rst_new_frame", rx_count - rx0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
